// File: rtl/cla_add_sub.sv
// cla_add_sub: registered two's-complement adder/subtractor for the RV32 ALU.
// The sum is formed by a two-level carry-lookahead network: 4-bit groups
// produce group propagate/generate, and a second-level lookahead unit derives
// every group carry-in directly from those signals and the carry-in, so no
// carry ripples from one group to the next. WIDTH must be a multiple of 4.
module cla_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             En,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] rs_1,
    input  logic [WIDTH-1:0] rs_2,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int NG = WIDTH / 4;

    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_c;
    logic             c_out_msb;
    logic             ov;

    // SUB is A + ~B + 1: invert B and inject the +1 as the carry-in.
    assign cin   = funct7_5;
    assign b_eff = funct7_5 ? ~rs_2 : rs_2;

    // Bit-level propagate / generate.
    assign p = rs_1 ^ b_eff;
    assign g = rs_1 & b_eff;

    // First level: bit carries inside each 4-bit group and the group P/G.
    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            localparam int B = 4 * gi;

            assign c[B]   = grp_c[gi];
            assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B])
                          | (p[B+1] & p[B] & grp_c[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1])
                          | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);

            assign grp_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];
            assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        end
    endgenerate

    // Second level: each group carry is an independent sum-of-products over
    // the lower groups' G/P and cin, never a function of another group carry.
    always_comb begin : second_level
        logic carry_acc;
        logic prod;
        carry_acc = 1'b0;
        prod      = 1'b0;
        grp_c     = '0;
        grp_c[0]  = cin;
        for (int k = 1; k < NG; k++) begin
            carry_acc = 1'b0;
            for (int j = 0; j < k; j++) begin
                prod = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & grp_p[m];
                end
                carry_acc = carry_acc | prod;
            end
            prod = cin;
            for (int m = 0; m < k; m++) begin
                prod = prod & grp_p[m];
            end
            grp_c[k] = carry_acc | prod;
        end
    end

    // Sum bits; carry-out of the MSB is only used for the overflow flag.
    assign sum       = p ^ c;
    assign c_out_msb = g[WIDTH-1] | (p[WIDTH-1] & c[WIDTH-1]);
    assign ov        = c[WIDTH-1] ^ c_out_msb;

    // Output register: load on En, hold otherwise, cleared asynchronously.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (En) begin
            result   <= sum;
            overflow <= ov;
        end
    end

endmodule

// File: tb/tb_cla_add_sub.sv
// Directed bench for cla_add_sub at WIDTH=4 and WIDTH=32 sharing one clock
// and reset. Expected values are hand-computed constants or derived from
// signed integer arithmetic in the bench.
module tb_cla_add_sub;

    logic        CLK;
    logic        rst_n;

    logic        en4, f4;
    logic [3:0]  a4, b4, res4;
    logic        ov4;

    logic        en32, f32;
    logic [31:0] a32, b32, res32;
    logic        ov32;

    int total = 0;
    int bad   = 0;

    cla_add_sub #(.WIDTH(4)) dut4 (
        .CLK(CLK), .rst_n(rst_n), .En(en4), .funct7_5(f4),
        .rs_1(a4), .rs_2(b4), .result(res4), .overflow(ov4)
    );

    cla_add_sub #(.WIDTH(32)) dut32 (
        .CLK(CLK), .rst_n(rst_n), .En(en32), .funct7_5(f32),
        .rs_1(a32), .rs_2(b32), .result(res32), .overflow(ov32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one 4-bit operation at the falling edge, sample #1 after the rising edge.
    task automatic op4(input logic en, input logic f, input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        en4 = en; f4 = f; a4 = a; b4 = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic op32(input logic en, input logic f, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        en32 = en; f32 = f; a32 = a; b32 = b;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int     sa, sb, r;
        longint la, lb, lr;
        logic [3:0]  e4;
        logic [31:0] e32;
        logic        eov;

        // Reset held with live inputs: outputs must be zero immediately.
        rst_n = 1'b0;
        en4 = 1'b1; f4 = 1'b0; a4 = 4'h7; b4 = 4'h7;
        en32 = 1'b1; f32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h1111_1111;
        #2;
        chk("rst_res4", {28'd0, res4}, 32'h0);
        chk("rst_ov4", {31'd0, ov4}, 32'h0);
        chk("rst_res32", res32, 32'h0);
        chk("rst_ov32", {31'd0, ov32}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_res4", {28'd0, res4}, 32'h0);
        chk("rst_hold_ov4", {31'd0, ov4}, 32'h0);
        chk("rst_hold_res32", res32, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        en32 = 1'b0;

        // Directed 4-bit add/sub cases.
        op4(1'b1, 1'b0, 4'h3, 4'h2);
        chk("add_3_2_res", {28'd0, res4}, 32'h5);
        chk("add_3_2_ov", {31'd0, ov4}, 32'h0);
        op4(1'b1, 1'b0, 4'h7, 4'h1);
        chk("add_7_1_res", {28'd0, res4}, 32'h8);
        chk("add_7_1_ov", {31'd0, ov4}, 32'h1);
        op4(1'b1, 1'b1, 4'h3, 4'h5);
        chk("sub_3_5_res", {28'd0, res4}, 32'hE);
        chk("sub_3_5_ov", {31'd0, ov4}, 32'h0);
        op4(1'b1, 1'b1, 4'h8, 4'h1);
        chk("sub_m8_1_res", {28'd0, res4}, 32'h7);
        chk("sub_m8_1_ov", {31'd0, ov4}, 32'h1);
        op4(1'b1, 1'b1, 4'h0, 4'h8);
        chk("sub_0_m8_res", {28'd0, res4}, 32'h8);
        chk("sub_0_m8_ov", {31'd0, ov4}, 32'h1);

        // Hold: load 2+2, then En low with 7+7 on the inputs for 3 edges.
        op4(1'b1, 1'b0, 4'h2, 4'h2);
        chk("hold_load_res", {28'd0, res4}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            op4(1'b0, 1'b0, 4'h7, 4'h7);
            chk("hold_res", {28'd0, res4}, 32'h4);
            chk("hold_ov", {31'd0, ov4}, 32'h0);
        end

        // Every 4-bit operand pair for both operations, one per cycle.
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    e4 = 4'(a);
                    sa = $signed(e4);
                    e4 = 4'(b);
                    sb = $signed(e4);
                    r   = (f == 1) ? (sa - sb) : (sa + sb);
                    e4  = r[3:0];
                    eov = (r > 7) || (r < -8);
                    op4(1'b1, f[0], 4'(a), 4'(b));
                    chk("sweep4_res", {28'd0, res4}, {28'd0, e4});
                    chk("sweep4_ov", {31'd0, ov4}, {31'd0, eov});
                end
            end
        end
        en4 = 1'b0;

        // Directed 32-bit cases.
        op32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("w32_ffff_p1_res", res32, 32'h0);
        chk("w32_ffff_p1_ov", {31'd0, ov32}, 32'h0);
        op32(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("w32_max_p1_res", res32, 32'h8000_0000);
        chk("w32_max_p1_ov", {31'd0, ov32}, 32'h1);
        op32(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
        chk("w32_min_m1_res", res32, 32'h7FFF_FFFF);
        chk("w32_min_m1_ov", {31'd0, ov32}, 32'h1);
        op32(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);
        chk("w32_0_mmin_res", res32, 32'h8000_0000);
        chk("w32_0_mmin_ov", {31'd0, ov32}, 32'h1);
        op32(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("w32_sub_mix_res", res32, 32'h7777_7788);
        chk("w32_sub_mix_ov", {31'd0, ov32}, 32'h0);
        op32(1'b1, 1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
        chk("w32_add_mix_res", res32, 32'h1010_1010);
        chk("w32_add_mix_ov", {31'd0, ov32}, 32'h0);

        // Random 32-bit operations against a 64-bit signed reference.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            logic        rf;
            ra = $urandom;
            rb = $urandom;
            rf = 1'($urandom_range(1, 0));
            la  = $signed(ra);
            lb  = $signed(rb);
            lr  = rf ? (la - lb) : (la + lb);
            e32 = lr[31:0];
            eov = (lr > 64'sd2147483647) || (lr < -64'sd2147483648);
            op32(1'b1, rf, ra, rb);
            chk("rand32_res", res32, e32);
            chk("rand32_ov", {31'd0, ov32}, {31'd0, eov});
        end

        // Async reset between edges, then first En edge after release.
        op4(1'b1, 1'b0, 4'h7, 4'h1);
        chk("pre_rst_res4", {28'd0, res4}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res4", {28'd0, res4}, 32'h0);
        chk("mid_rst_ov4", {31'd0, ov4}, 32'h0);
        chk("mid_rst_res32", res32, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        op4(1'b1, 1'b0, 4'h1, 4'h1);
        chk("post_rst_res4", {28'd0, res4}, 32'h2);
        chk("post_rst_ov4", {31'd0, ov4}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
